// File: rtl/gold_nic_pkg.sv
// Shared constants and types for the GOLD network interface.
// Register-select codes and the packet width used by every node.
package gold_nic_pkg;
  localparam int PKT_W = 64;

  localparam logic [1:0] ADDR_IBUF  = 2'b00;
  localparam logic [1:0] ADDR_ISTAT = 2'b01;
  localparam logic [1:0] ADDR_OBUF  = 2'b10;
  localparam logic [1:0] ADDR_OSTAT = 2'b11;

  typedef logic [0:PKT_W-1] pkt_t;
endpackage

// File: rtl/gold_nic_chan_buf.sv
// One-entry packet buffer with a full flag.
// The stored data persists after clear; only the flag drops.
module nic_chan_buf
  import gold_nic_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic load,
  input  logic clear,
  input  pkt_t load_data,
  output pkt_t data,
  output logic full
);
  pkt_t data_reg;
  logic full_reg;

  // Load wins over clear so an arriving packet is never lost.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_reg <= '0;
      full_reg <= 1'b0;
    end else if (load) begin
      data_reg <= load_data;
      full_reg <= 1'b1;
    end else if (clear) begin
      full_reg <= 1'b0;
    end
  end

  assign data = data_reg;
  assign full = full_reg;
endmodule

// File: rtl/gold_nic.sv
// GOLD node network interface: one output and one input packet buffer
// between the processor register bus and the router port.
module gold_nic
  import gold_nic_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [0:1]  addr,
  input  logic [0:63] d_in,
  output logic [0:63] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  output logic        net_so,
  input  logic        net_ro,
  output logic [0:63] net_do,
  input  logic        net_polarity,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [0:63] net_di
);
  pkt_t obuf;
  pkt_t ibuf;
  logic ofull;
  logic ifull;
  logic proc_rd;
  logic proc_wr;
  logic o_load;
  logic i_load;
  logic i_clear;

  assign proc_rd = nicEn & ~nicWrEn;
  assign proc_wr = nicEn & nicWrEn;

  // A write to a full obuf (including the send cycle) is silently dropped.
  assign o_load  = proc_wr & (addr == ADDR_OBUF) & ~ofull;
  assign net_so  = ~RESET & ofull & net_ro & (net_polarity == obuf[0]);
  assign net_do  = obuf;

  assign net_ri  = ~RESET & ~ifull;
  assign i_load  = net_si & net_ri;
  assign i_clear = proc_rd & (addr == ADDR_IBUF);

  nic_chan_buf u_obuf (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (o_load),
    .clear     (net_so),
    .load_data (d_in),
    .data      (obuf),
    .full      (ofull)
  );

  nic_chan_buf u_ibuf (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (i_load),
    .clear     (i_clear),
    .load_data (net_di),
    .data      (ibuf),
    .full      (ifull)
  );

  always_comb begin
    d_out = '0;
    if (proc_rd) begin
      case (addr)
        ADDR_IBUF:  d_out = ibuf;
        ADDR_ISTAT: d_out = {63'b0, ifull};
        ADDR_OBUF:  d_out = obuf;
        ADDR_OSTAT: d_out = {63'b0, ofull};
        default:    d_out = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_gold_nic.sv
// Scoreboard bench for gold_nic: expected packets are queued when driven
// and compared when the DUT sends them or the processor reads them back.
module tb_gold_nic;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;

  logic [63:0] txq[$];
  logic [63:0] rxq[$];
  int n_assert = 0;
  int n_fail   = 0;

  gold_nic dut (
    .CLK(CLK), .RESET(RESET), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus(input logic en, input logic we, input logic [1:0] a, input logic [63:0] d);
    nicEn = en; nicWrEn = we; addr = a; d_in = d;
  endtask

  task automatic test_reset();
    RESET = 1'b1; net_ro = 1'b1; net_polarity = 1'b0;
    net_si = 1'b0; net_di = '0;
    bus(1'b0, 1'b0, 2'b00, 64'h0);
    step(); step();
    for (int a = 0; a < 4; a++) begin
      bus(1'b1, 1'b0, a[1:0], 64'h0);
      @(negedge CLK);
      n_assert++;
      if (d_out !== 64'h0) begin
        n_fail++; $display("FAIL reset_read addr=%0d: got %h want 0", a, d_out);
      end
      n_assert++;
      if (net_so !== 1'b0 || net_ri !== 1'b0) begin
        n_fail++; $display("FAIL reset_strobes: so=%b ri=%b want 0 0", net_so, net_ri);
      end
      step();
    end
    RESET = 1'b0;
    bus(1'b0, 1'b0, 2'b00, 64'h0);
    step();
    @(negedge CLK);
    n_assert++;
    if (net_ri !== 1'b1 || net_so !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: ri=%b so=%b want 1 0", net_ri, net_so);
    end
    $display("reset done");
  endtask

  task automatic check_send(input string name);
    logic [63:0] exp;
    n_assert++;
    if (net_so !== 1'b1) begin
      n_fail++; $display("FAIL %s_so: got %b want 1", name, net_so);
    end else if (txq.size() == 0) begin
      n_fail++; $display("FAIL %s_unexpected_send: net_do=%h", name, net_do);
    end else begin
      exp = txq.pop_front();
      n_assert++;
      if (net_do !== exp) begin
        n_fail++; $display("FAIL %s_do: got %h want %h", name, net_do, exp);
      end
      $display("tx %s sent %h", name, net_do);
    end
  endtask

  task automatic check_no_send(input string name);
    n_assert++;
    if (net_so !== 1'b0) begin
      n_fail++; $display("FAIL %s_nosend: net_so got %b want 0", name, net_so);
    end
  endtask

  task automatic check_read(input string name, input logic [1:0] a, input logic [63:0] exp);
    bus(1'b1, 1'b0, a, 64'h0);
    @(negedge CLK);
    n_assert++;
    if (d_out !== exp) begin
      n_fail++; $display("FAIL %s: addr=%b got %h want %h", name, a, d_out, exp);
    end
    $display("read %s addr=%b data=%h", name, a, d_out);
  endtask

  task automatic test_send_basic();
    net_ro = 1'b1; net_polarity = 1'b0;
    step();
    bus(1'b1, 1'b1, 2'b10, 64'h0000_0000_0000_00AA);
    txq.push_back(64'h0000_0000_0000_00AA);
    @(negedge CLK);
    check_no_send("basic_before");
    step();
    bus(1'b0, 1'b0, 2'b00, 64'h0);
    @(negedge CLK);
    check_send("basic");
    step();
    check_read("basic_ostat", 2'b11, 64'h0);
    check_no_send("basic_after");
  endtask

  task automatic test_polarity();
    net_ro = 1'b1; net_polarity = 1'b0;
    step();
    bus(1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_0055);
    txq.push_back(64'h8000_0000_0000_0055);
    step();
    check_read("pol_ostat_held", 2'b11, 64'h1);
    check_no_send("pol_wrong_phase0");
    step();
    bus(1'b0, 1'b0, 2'b00, 64'h0);
    @(negedge CLK);
    check_no_send("pol_wrong_phase1");
    step();
    net_polarity = 1'b1;
    @(negedge CLK);
    check_send("pol");
    step();
    @(negedge CLK);
    check_no_send("pol_one_cycle");
    net_polarity = 1'b0;
  endtask

  task automatic test_receive();
    step();
    bus(1'b0, 1'b0, 2'b00, 64'h0);
    net_si = 1'b1; net_di = 64'h1234;
    @(negedge CLK);
    n_assert++;
    if (net_ri !== 1'b1) begin
      n_fail++; $display("FAIL rx_ready: got %b want 1", net_ri);
    end
    rxq.push_back(64'h1234);
    step();
    net_si = 1'b0; net_di = 64'hDEAD;
    check_read("rx_istat_full", 2'b01, 64'h1);
    n_assert++;
    if (net_ri !== 1'b0) begin
      n_fail++; $display("FAIL rx_ri_full: got %b want 0", net_ri);
    end
    step();
    check_read("rx_ibuf", 2'b00, rxq.pop_front());
    step();
    check_read("rx_istat_empty", 2'b01, 64'h0);
    n_assert++;
    if (net_ri !== 1'b1) begin
      n_fail++; $display("FAIL rx_ri_empty: got %b want 1", net_ri);
    end
    step();
    check_read("rx_stale", 2'b00, 64'h1234);
    step();
    check_read("rx_stale_istat", 2'b01, 64'h0);
  endtask

  task automatic test_hold_write();
    net_ro = 1'b0; net_polarity = 1'b0;
    step();
    bus(1'b1, 1'b1, 2'b10, 64'h11);
    txq.push_back(64'h11);
    step();
    bus(1'b1, 1'b1, 2'b10, 64'h22);
    @(negedge CLK);
    check_no_send("hold_ro_low");
    step();
    check_read("hold_obuf", 2'b10, 64'h11);
    step();
    bus(1'b0, 1'b0, 2'b00, 64'h0);
    net_ro = 1'b1;
    @(negedge CLK);
    check_send("hold");
    step();
    check_read("hold_ostat", 2'b11, 64'h0);
    check_no_send("hold_after");
  endtask

  task automatic test_ignored_writes();
    for (int a = 0; a < 4; a++) begin
      if (a != 2) begin
        step();
        bus(1'b1, 1'b1, a[1:0], 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
    step();
    check_read("ign_ibuf", 2'b00, 64'h1234);
    step();
    check_read("ign_istat", 2'b01, 64'h0);
    step();
    check_read("ign_ostat", 2'b11, 64'h0);
    step();
    check_read("ign_obuf", 2'b10, 64'h11);
  endtask

  task automatic test_back_to_back();
    net_ro = 1'b1; net_polarity = 1'b0;
    step();
    bus(1'b1, 1'b1, 2'b10, 64'h0BAD);
    txq.push_back(64'h0BAD);
    step();
    bus(1'b1, 1'b1, 2'b10, 64'h77);
    net_si = 1'b1; net_di = 64'hCAFE;
    @(negedge CLK);
    n_assert++;
    if (net_ri !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ri: got %b want 1", net_ri);
    end
    rxq.push_back(64'hCAFE);
    check_send("b2b");
    step();
    net_si = 1'b0;
    check_read("b2b_ostat", 2'b11, 64'h0);
    n_assert++;
    if (net_ri !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ri_full: got %b want 0", net_ri);
    end
    step();
    check_read("b2b_istat", 2'b01, 64'h1);
    step();
    check_read("b2b_ibuf", 2'b00, rxq.pop_front());
    step();
    check_read("b2b_istat_clr", 2'b01, 64'h0);
    step();
    check_read("b2b_obuf", 2'b10, 64'h0BAD);
  endtask

  task automatic test_reset_mid();
    net_ro = 1'b0; net_polarity = 1'b0;
    step();
    bus(1'b1, 1'b1, 2'b10, 64'h99);
    net_si = 1'b1; net_di = 64'h55;
    step();
    net_si = 1'b0;
    check_read("mid_ostat_set", 2'b11, 64'h1);
    n_assert++;
    if (net_ri !== 1'b0) begin
      n_fail++; $display("FAIL mid_ri_full: got %b want 0", net_ri);
    end
    step();
    RESET = 1'b1; net_ro = 1'b1;
    bus(1'b0, 1'b0, 2'b00, 64'h0);
    @(negedge CLK);
    check_no_send("mid_in_reset");
    step();
    RESET = 1'b0;
    check_read("mid_ostat_clr", 2'b11, 64'h0);
    check_no_send("mid_after_reset");
    step();
    check_read("mid_istat_clr", 2'b01, 64'h0);
    step();
    check_read("mid_ibuf_clr", 2'b00, 64'h0);
    step();
    check_read("mid_obuf_clr", 2'b10, 64'h0);
  endtask

  initial begin
    test_reset();
    test_send_basic();
    test_polarity();
    test_receive();
    test_hold_write();
    test_ignored_writes();
    test_back_to_back();
    test_reset_mid();
    n_assert++;
    if (txq.size() != 0 || rxq.size() != 0) begin
      n_fail++; $display("FAIL queues_drained: tx=%0d rx=%0d want 0 0", txq.size(), rxq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
